// File: rtl/pmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : pmem_arbiter
// Purpose  : Shares one physical-memory port between the read-only I-cache
//            and the read/write D-cache. One requester is granted at a time,
//            the grant is held until memory signals completion, the response
//            is routed only to the granted cache, and a one-cycle idle gap
//            separates consecutive transactions.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            i_pmem_*             - I-cache side (read request, address,
//                                   returned line data, completion)
//            d_pmem_*             - D-cache side (read / write-back request,
//                                   address, write data, returned line data,
//                                   completion)
//            pmem_*               - physical memory side (strobes, address,
//                                   write data, read data, completion)
// Options  : ARB_ROUND_ROBIN_EN  - when defined, simultaneous I/D requests
//                                   alternate via a 1-bit priority register
//                                   (reset D-first); otherwise the D-cache
//                                   always wins.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pmem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    // I-cache side
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    // D-cache side
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    // Physical memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] c_idle_s    = 2'd0;
    localparam logic [1:0] c_icache_s  = 2'd1;
    localparam logic [1:0] c_dcache_s  = 2'd2;
    localparam logic [1:0] c_release_s = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    logic w_d_req;
    logic w_grant_d;
    logic w_grant_i;

    assign w_d_req = d_pmem_read | d_pmem_write;

    // Read data needs no steering: each cache only samples it while its own
    // resp is high, and only the granted cache ever sees resp.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = I-cache wins the next tie, 0 = D-cache wins the next tie.
    logic r_prio_i;

    // A lone requester is always granted; the priority bit only breaks ties.
    assign w_grant_d = w_d_req & (~i_pmem_read | ~r_prio_i);
    assign w_grant_i = i_pmem_read & ~w_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio_i <= 1'b0;
        end else if (r_state == c_idle_s) begin
            if (w_grant_d) begin
                r_prio_i <= 1'b1;
            end else if (w_grant_i) begin
                r_prio_i <= 1'b0;
            end
        end
    end
`else
    // Fixed priority: a D-cache miss stalls the memory stage, whereas an
    // I-cache miss only stalls fetch, so the D-cache always wins a tie.
    assign w_grant_d = w_d_req;
    assign w_grant_i = i_pmem_read & ~w_d_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle_s;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        case (r_state)
            c_idle_s: begin
                // pmem_resp is deliberately ignored here.
                if (w_grant_d) begin
                    w_state_next = c_dcache_s;
                end else if (w_grant_i) begin
                    w_state_next = c_icache_s;
                end
            end

            c_icache_s: begin
                // If the I-cache drops its request early the strobe follows
                // it, but the grant is held until memory completes.
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    w_state_next = c_release_s;
                end
            end

            c_dcache_s: begin
                // A write-back takes precedence over a read if both are set.
                pmem_write   = d_pmem_write;
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    w_state_next = c_release_s;
                end
            end

            c_release_s: begin
                // Gap cycle: the finished cache drops its request and memory
                // observes a deasserted strobe before the next grant.
                w_state_next = c_idle_s;
            end

            default: begin
                w_state_next = c_idle_s;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_pmem_arbiter
// Purpose  : Directed self-checking bench for pmem_arbiter. Memory responses
//            are driven by hand at fixed cycles; expected values are
//            hand-computed constants.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pmem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk;
    logic              reset;
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int checks   = 0;
    int failures = 0;

    pmem_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed and outputs sampled 1 ns
    // after the rising edge, away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample combinational outputs after inputs were just changed.
    task automatic settle();
        #1;
    endtask

    // Expected grant sequence for four back-to-back ties: 1 = D, 0 = I.
    logic [3:0] tie_order;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        tie_order = 4'b0101;   // index 0 first: D, I, D, I
`else
        tie_order = 4'b1111;   // D every time
`endif
        reset          = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        settle();

        // Reset state
        check("rst_pmem_read",  128'(pmem_read),    128'd0);
        check("rst_pmem_write", 128'(pmem_write),   128'd0);
        check("rst_i_resp",     128'(i_pmem_resp),  128'd0);
        check("rst_d_resp",     128'(d_pmem_resp),  128'd0);
        check("rst_addr",       128'(pmem_address), 128'd0);
        check("rst_wdata",      pmem_wdata,         128'd0);

        // I-cache read alone, memory answers on the third granted cycle
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1230;
        settle();
        check("i_arb_latency", 128'(pmem_read), 128'd0);
        tick();
        check("i_read_c1",  128'(pmem_read),    128'd1);
        check("i_addr_c1",  128'(pmem_address), 128'h1230);
        check("i_write_c1", 128'(pmem_write),   128'd0);
        tick();
        tick();
        check("i_read_c3",  128'(pmem_read),    128'd1);
        check("i_noresp_c3", 128'(i_pmem_resp), 128'd0);
        pmem_resp  = 1'b1;
        pmem_rdata = 128'hA5;
        settle();
        check("i_resp",      128'(i_pmem_resp), 128'd1);
        check("i_rdata",     i_pmem_rdata,      128'hA5);
        check("i_d_resp_lo", 128'(d_pmem_resp), 128'd0);
        tick();
        // release_s: strobes down, a stray resp is not forwarded
        check("i_rel_read", 128'(pmem_read), 128'd0);
        check("i_rel_resp", 128'(i_pmem_resp), 128'd0);
        check("i_rel_d_resp", 128'(d_pmem_resp), 128'd0);
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        tick();

        // D-cache write-back alone
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h4560;
        d_pmem_wdata   = 128'hDEAD;
        tick();
        check("dw_write", 128'(pmem_write),   128'd1);
        check("dw_read",  128'(pmem_read),    128'd0);
        check("dw_addr",  128'(pmem_address), 128'h4560);
        check("dw_wdata", pmem_wdata,         128'hDEAD);
        tick();
        check("dw_write_c2", 128'(pmem_write), 128'd1);
        pmem_resp = 1'b1;
        settle();
        check("dw_resp",      128'(d_pmem_resp), 128'd1);
        check("dw_i_resp_lo", 128'(i_pmem_resp), 128'd0);
        tick();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        settle();
        check("dw_rel_write", 128'(pmem_write),  128'd0);
        check("dw_rel_resp",  128'(d_pmem_resp), 128'd0);
        tick();

        // Re-establish D-first priority before the tie sequence
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Simultaneous I read 0x0010 and D read 0x8000, held across grants
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0010;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h8000;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (tie_order[k]) begin
                check($sformatf("tie%0d_addr_d", k), 128'(pmem_address), 128'h8000);
            end else begin
                check($sformatf("tie%0d_addr_i", k), 128'(pmem_address), 128'h0010);
            end
            check($sformatf("tie%0d_read", k), 128'(pmem_read), 128'd1);
            pmem_resp  = 1'b1;
            pmem_rdata = 128'h1000 + 128'(k);
            settle();
            check($sformatf("tie%0d_d_resp", k), 128'(d_pmem_resp), 128'(tie_order[k]));
            check($sformatf("tie%0d_i_resp", k), 128'(i_pmem_resp), 128'(!tie_order[k]));
            if (tie_order[k]) begin
                check($sformatf("tie%0d_d_rdata", k), d_pmem_rdata, 128'h1000 + 128'(k));
            end else begin
                check($sformatf("tie%0d_i_rdata", k), i_pmem_rdata, 128'h1000 + 128'(k));
            end
            tick();
            pmem_resp = 1'b0;
            settle();
            check($sformatf("tie%0d_rel_read", k), 128'(pmem_read), 128'd0);
            tick();
        end
        i_pmem_read = 1'b0;

        // D read followed by the I read after a D-first tie (fixed-order view)
        // is covered above; now reset in the middle of a D transaction.
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h0ABC;
        tick();
        check("mid_read", 128'(pmem_read), 128'd1);
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        d_pmem_read = 1'b0;
        settle();
        check("mid_rst_read", 128'(pmem_read),    128'd0);
        check("mid_rst_addr", 128'(pmem_address), 128'd0);
        pmem_resp = 1'b1;
        settle();
        check("late_d_resp", 128'(d_pmem_resp), 128'd0);
        check("late_i_resp", 128'(i_pmem_resp), 128'd0);
        tick();
        check("late_idle_read", 128'(pmem_read),   128'd0);
        check("late_idle_resp", 128'(d_pmem_resp), 128'd0);
        pmem_resp = 1'b0;
        tick();

        // Read and write together: write wins
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h2000;
        d_pmem_wdata   = 128'h55;
        tick();
        check("rw_write", 128'(pmem_write),   128'd1);
        check("rw_read",  128'(pmem_read),    128'd0);
        check("rw_addr",  128'(pmem_address), 128'h2000);
        pmem_resp = 1'b1;
        settle();
        check("rw_resp", 128'(d_pmem_resp), 128'd1);
        tick();
        pmem_resp    = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        tick();
        check("end_idle_write", 128'(pmem_write), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares one physical-memory port between the split instruction cache (read-only) and data cache (read/write).
- Sits between both cache controllers and physical memory.
- Grants one requester at a time and holds the grant until memory completes the line transfer.
- Routes the response only to the granted cache and forces an idle gap cycle between transactions.

Parameters:
ADDR_W, 16, physical line address width (lc3b_pmem_addr)
LINE_W, 128, cache line width in bits

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
i_pmem_read  input  1  I-cache line read request
i_pmem_address  input  ADDR_W  I-cache line address
i_pmem_rdata  output  LINE_W  line data to I-cache
i_pmem_resp  output  1  I-cache transfer complete
d_pmem_read  input  1  D-cache line read request
d_pmem_write  input  1  D-cache line write-back request
d_pmem_address  input  ADDR_W  D-cache line address
d_pmem_wdata  input  LINE_W  D-cache write-back data
d_pmem_rdata  output  LINE_W  line data to D-cache
d_pmem_resp  output  1  D-cache transfer complete
pmem_read  output  1  memory read strobe
pmem_write  output  1  memory write strobe
pmem_address  output  ADDR_W  memory line address
pmem_wdata  output  LINE_W  memory write data
pmem_rdata  input  LINE_W  memory read data
pmem_resp  input  1  memory transfer complete

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- States: idle_s, icache_s, dcache_s, release_s. State register updates on posedge clk only.
- reset=1 at a clock edge:
  - state <= idle_s and priority bit <= D-first.
  - Applies mid-transaction; the in-flight transfer is abandoned.
  - A pmem_resp arriving in idle_s is ignored.
- Reset-state outputs: pmem_read=0, pmem_write=0, i_pmem_resp=0, d_pmem_resp=0, pmem_address=0, pmem_wdata=0.
- i_pmem_rdata and d_pmem_rdata are continuous pass-throughs of pmem_rdata in all states. They are meaningful only while the matching resp is 1.
- idle_s:
  - All memory strobes 0; no resp driven.
  - D request only (d_pmem_read|d_pmem_write) -> dcache_s.
  - I request only -> icache_s.
  - Both requesting -> dcache_s (D-cache priority). A D miss stalls MEM while I stalls only fetch.
  - Grant takes effect the cycle after the request is seen: 1-cycle arbitration latency.
- icache_s:
  - pmem_read=i_pmem_read; pmem_address=i_pmem_address; pmem_write=0; pmem_wdata=0.
  - i_pmem_resp=pmem_resp combinationally (same cycle); d_pmem_resp=0.
  - pmem_resp=1 -> release_s. Otherwise stay.
  - If i_pmem_read drops before resp (protocol violation), strobes go 0 and the arbiter stays in icache_s until pmem_resp.
- dcache_s:
  - pmem_address=d_pmem_address; pmem_wdata=d_pmem_wdata.
  - pmem_write=d_pmem_write; pmem_read=d_pmem_read & ~d_pmem_write. Write wins if both are asserted.
  - d_pmem_resp=pmem_resp; i_pmem_resp=0.
  - pmem_resp=1 -> release_s.
- release_s:
  - Exactly one cycle, all strobes 0, no resp.
  - Lets the finished cache drop its request and memory see a deasserted strobe.
  - Always -> idle_s.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles.
- A requester's address and data must be held stable by the cache until its resp. The arbiter does not latch them.
- pmem_resp while in idle_s or release_s: ignored, no resp forwarded.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit priority register decides simultaneous I and D requests in idle_s.
  - Each grant sets priority to the other requester.
  - Reset value is D-first.
  - A single requester is always granted regardless of the priority bit.
- Undefined: fixed D-cache priority as described above; no priority register is synthesized.

Test Plan:
- I-cache read alone: i_pmem_read=1, addr 0x1230. Memory responds after 3 cycles with 128'hA5.
  -> pmem_read=1 and pmem_address=0x1230 from cycle 1; i_pmem_resp=1 for one cycle with i_pmem_rdata=128'hA5; d_pmem_resp stays 0; release_s follows.
- D-cache write-back alone: d_pmem_write=1, addr 0x4560, wdata 128'hDEAD.
  -> pmem_write=1, pmem_read=0, pmem_wdata=128'hDEAD until pmem_resp; d_pmem_resp pulses once.
- Simultaneous I read 0x0010 and D read 0x8000 in idle_s, macro undefined.
  -> D served first with pmem_address=0x8000; release_s; then I served at 0x0010; i_pmem_resp occurs after d_pmem_resp.
- Same simultaneous requests repeated three times with ARB_ROUND_ROBIN_EN.
  -> grant order D, I, D, I, D, I; each completes its own resp.
- Reset asserted in dcache_s before pmem_resp, followed by a late pmem_resp=1.
  -> next cycle state idle_s with all strobes 0; late pmem_resp produces no i_/d_pmem_resp.
- d_pmem_read=1 and d_pmem_write=1 together, addr 0x2000.
  -> pmem_write=1, pmem_read=0, pmem_address=0x2000.
